rs_rd_fetch_engine: RTL and testbench
=====================================

Name: rs_rd_fetch_engine

Overview:
- Host-read stage directly upstream of the Reed-Solomon decoder core. Runs on the CCI-P c0 channel.
- On start, it takes a buffer descriptor (byte address and byte size) from the HardCloud buffer registers and issues cache-line read requests.
- Responses may arrive out of order. They are collected in a tag-indexed reorder buffer.
- 512-bit blocks are delivered in address order to the decoder over a valid/ready stream.

Parameters:
- MAX_OUTSTANDING, 16: read-request tags / reorder slots. Power of 2, range 2..64.
- TAG_W, $clog2(MAX_OUTSTANDING): tag width carried in mdata[TAG_W-1:0].
- ADDR_W, 42: cache-line address width (CCI-P c0 request address).

Ports:
- clk  in  1  user clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in S_RD_IDLE
- buf_addr  in  64  buffer byte address (t_hc_address); bits [5:0] ignored
- buf_size  in  32  buffer size in bytes
- rd_req_valid  out  1  c0 read request valid
- rd_req_addr  out  ADDR_W  cache-line address = buf_addr[47:6] + line index
- rd_req_mdata  out  16  {zeros, tag}
- c0_tx_alm_full  in  1  c0 almost-full; no request issued while high
- rd_rsp_valid  in  1  c0 read response valid (resp type already qualified)
- rd_rsp_mdata  in  16  response tag in [TAG_W-1:0]
- rd_rsp_data  in  512  response line
- blk_valid  out  1  t_block valid to decoder
- blk_data  out  512  t_block data
- blk_last  out  1  marks the final block of the buffer
- blk_ready  in  1  decoder accepts block
- busy  out  1  high in any state other than S_RD_IDLE
- done  out  1  one-cycle pulse when the last block is accepted
- perf_cycles  out  32  see Optional Feature
- perf_stalls  out  32  see Optional Feature

Behaviour:
- Reset (async, rst_n low): state S_RD_IDLE; all counters 0; valid bitmap cleared.
  - Output reset values: rd_req_valid=0, blk_valid=0, blk_last=0, done=0, busy=0, perf_*=0.
  - rd_req_addr, rd_req_mdata and blk_data reset to 0.
  - Reset mid-operation abandons all outstanding tags. Late responses after reset are ignored because the bitmap is cleared and state is IDLE.
- Line count: n_lines = (buf_size + 63) >> 6, 27 bits, computed at start.
- Tag and ordering:
  - Request i uses tag i mod MAX_OUTSTANDING.
  - Delivery is strictly in order of i.
- State machine (t_rd_state):
  - S_RD_IDLE: on start, latch addr and n_lines, clear counters.
    - n_lines==0 -> S_RD_FINISH.
    - Otherwise -> S_RD_FETCH.
  - S_RD_FETCH: issue at most one request per cycle, and only when all of these hold:
    - c0_tx_alm_full==0
    - issued - delivered < MAX_OUTSTANDING
    - slot[tag] is empty
    - rd_req_valid is a registered output, asserted exactly one cycle per request.
    - When issued==n_lines -> S_RD_WAIT.
  - S_RD_WAIT: no requests. When delivered==n_lines -> S_RD_FINISH.
  - S_RD_FINISH: pulse done for 1 cycle -> S_RD_IDLE. For n_lines==0, done fires 2 cycles after start.
- Response write: rd_rsp_valid writes rd_rsp_data into slot[tag] and sets bitmap[tag].
  - A response to an already-valid slot, or received while in IDLE, is dropped. Verification checks that this never happens in normal runs.
- Output:
  - blk_valid = bitmap[head] in FETCH or WAIT. blk_data = slot[head].
  - blk_last = (delivered == n_lines-1).
  - On blk_valid && blk_ready: clear bitmap[head], head++, delivered++.
  - blk_valid/blk_data stay stable while blk_ready is low.
- Simultaneous events:
  - Response write and delivery in the same cycle to different slots: both take effect.
  - Same slot in the same cycle cannot occur, because the bitmap gates it.
- Wrap-around:
  - Tags and head wrap modulo MAX_OUTSTANDING.
  - rd_req_addr addition wraps at ADDR_W bits without error.
- start while busy is ignored.
- Latency: response to blk_valid is 1 cycle (registered bitmap). start to first rd_req_valid is 2 cycles.

Optional Feature:
- Macro RS_RD_PERF_CNT_EN.
- When defined:
  - perf_cycles counts cycles with busy high, saturating at 2^32-1.
  - perf_stalls counts cycles in S_RD_FETCH where a request was blocked by c0_tx_alm_full or the outstanding limit, saturating.
  - Both counters clear on an accepted start.
- When undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- buf_size=0, start -> no rd_req_valid; done 2 cycles after start; no blk_valid.
- buf_size=200, buf_addr=0x1000, in-order responses, blk_ready=1:
  - 4 requests to lines 0x40..0x43, tags 0..3.
  - 4 blocks in order; blk_last on the 4th; done once.
- 8 lines, responses returned in reverse tag order 7..0 -> blocks emitted in address order 0..7. First blk_valid only after tag 0 arrives.
- 40 lines, MAX_OUTSTANDING=16, responses delayed 50 cycles -> never more than 16 outstanding; all 40 blocks delivered in order with matching data.
- c0_tx_alm_full held high for 20 cycles mid-FETCH, plus blk_ready toggled randomly:
  - No request issued while alm_full is high.
  - blk_data stable during backpressure.
  - With RS_RD_PERF_CNT_EN, perf_stalls ≥ 20.
- rst_n asserted with 5 tags outstanding, then released with the late responses still injected -> outputs at reset values; no blk_valid; the next start runs cleanly.

Source files
------------

// File: rtl/rs_rd_fetch_engine.sv
// Purpose: CCI-P c0 host-read front end for the Reed-Solomon decoder. It issues cache-line
//          reads for one buffer, reorders the responses by tag and streams 512-bit blocks in order.
// Latency: start to first rd_req_valid is 2 cycles; a response reaches blk_valid 1 cycle later.
// Backpressure: no request while c0_tx_alm_full is high or MAX_OUTSTANDING reads are in flight;
//               blk_valid/blk_data are held while blk_ready is low.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, buf_addr, buf_size  buffer descriptor, sampled on start in S_RD_IDLE
//   rd_req_*, c0_tx_alm_full   c0 read request channel (tag in rd_req_mdata[TAG_W-1:0])
//   rd_rsp_*                   c0 read response channel (tag in rd_rsp_mdata[TAG_W-1:0])
//   blk_*                      in-order block stream to the decoder
//   busy, done                 status; done pulses once per buffer
//   perf_cycles, perf_stalls   performance counters, built only with RS_RD_PERF_CNT_EN
// Optional feature macro: RS_RD_PERF_CNT_EN (undefined -> perf ports tied to 0).
module rs_rd_fetch_engine #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_W           = $clog2(MAX_OUTSTANDING),
  parameter int ADDR_W          = 42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       buf_addr,
  input  logic [31:0]       buf_size,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_req_mdata,
  input  logic              c0_tx_alm_full,
  input  logic              rd_rsp_valid,
  input  logic [15:0]       rd_rsp_mdata,
  input  logic [511:0]      rd_rsp_data,
  output logic              blk_valid,
  output logic [511:0]      blk_data,
  output logic              blk_last,
  input  logic              blk_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
);

  localparam logic [1:0] S_RD_IDLE   = 2'd0;
  localparam logic [1:0] S_RD_FETCH  = 2'd1;
  localparam logic [1:0] S_RD_WAIT   = 2'd2;
  localparam logic [1:0] S_RD_FINISH = 2'd3;
  localparam int         CNT_W       = 27;

  logic [1:0]                 state_q, state_d;
  logic [ADDR_W-1:0]          base_q, base_d;
  logic [CNT_W-1:0]           n_lines_q, n_lines_d;
  logic [CNT_W-1:0]           issued_q, issued_d;
  logic [CNT_W-1:0]           delivered_q, delivered_d;
  logic [MAX_OUTSTANDING-1:0] bitmap_q, bitmap_d;
  logic                       req_vld_q, req_vld_d;
  logic [ADDR_W-1:0]          req_addr_q, req_addr_d;
  logic [15:0]                req_mdata_q, req_mdata_d;
  logic                       done_q, done_d;
  logic [511:0]               slot_q [MAX_OUTSTANDING];

  logic [TAG_W-1:0] head, issue_tag, rsp_tag;
  logic [32:0]      size_rnd;
  logic [CNT_W-1:0] n_lines_calc, in_flight;
  logic             room, all_issued, issue, rsp_wr, deliver;
  logic             unused_ok;

  // Head of the reorder buffer is the tag of the next block to deliver.
  assign head         = delivered_q[TAG_W-1:0];
  assign issue_tag    = issued_q[TAG_W-1:0];
  assign rsp_tag      = rd_rsp_mdata[TAG_W-1:0];
  // 33-bit sum so a buffer size near 4 GiB cannot overflow while rounding up.
  assign size_rnd     = {1'b0, buf_size} + 33'd63;
  assign n_lines_calc = size_rnd[32:6];
  assign in_flight    = issued_q - delivered_q;
  assign room         = in_flight < CNT_W'(MAX_OUTSTANDING);
  assign all_issued   = (issued_q == n_lines_q);
  assign issue        = (state_q == S_RD_FETCH) && !all_issued && !c0_tx_alm_full && room &&
                        !bitmap_q[issue_tag];
  // Responses are only accepted while a buffer is active and into an empty slot.
  assign rsp_wr       = rd_rsp_valid && (state_q != S_RD_IDLE) && !bitmap_q[rsp_tag];
  assign blk_valid    = ((state_q == S_RD_FETCH) || (state_q == S_RD_WAIT)) && bitmap_q[head];
  assign deliver      = blk_valid && blk_ready;
  assign blk_data     = slot_q[head];
  assign blk_last     = (delivered_q == n_lines_q - 27'd1);
  assign busy         = (state_q != S_RD_IDLE);
  assign done         = done_q;
  assign rd_req_valid = req_vld_q;
  assign rd_req_addr  = req_addr_q;
  assign rd_req_mdata = req_mdata_q;
  assign unused_ok    = ^{buf_addr[5:0], buf_addr[63:ADDR_W+6], rd_rsp_mdata[15:TAG_W]};

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_lines_d   = n_lines_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    bitmap_d    = bitmap_q;
    req_vld_d   = 1'b0;
    req_addr_d  = req_addr_q;
    req_mdata_d = req_mdata_q;
    done_d      = 1'b0;
    // Write and delivery always hit different slots: write needs the bit clear, delivery needs it set.
    if (rsp_wr) bitmap_d[rsp_tag] = 1'b1;
    if (deliver) begin
      bitmap_d[head] = 1'b0;
      delivered_d    = delivered_q + 27'd1;
    end
    case (state_q)
      S_RD_IDLE: begin
        if (start) begin
          base_d      = buf_addr[ADDR_W+5:6];
          n_lines_d   = n_lines_calc;
          issued_d    = '0;
          delivered_d = '0;
          bitmap_d    = '0;
          state_d     = (n_lines_calc == '0) ? S_RD_FINISH : S_RD_FETCH;
        end
      end
      S_RD_FETCH: begin
        if (all_issued) begin
          state_d = S_RD_WAIT;
        end else if (issue) begin
          req_vld_d   = 1'b1;
          req_addr_d  = base_q + ADDR_W'(issued_q);  // wraps at ADDR_W bits
          req_mdata_d = 16'(issue_tag);
          issued_d    = issued_q + 27'd1;
        end
      end
      S_RD_WAIT: begin
        if (delivered_q == n_lines_q) state_d = S_RD_FINISH;
      end
      S_RD_FINISH: begin
        done_d  = 1'b1;
        state_d = S_RD_IDLE;
      end
      default: state_d = S_RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RD_IDLE;
      base_q      <= '0;
      n_lines_q   <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      bitmap_q    <= '0;
      req_vld_q   <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_lines_q   <= n_lines_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      bitmap_q    <= bitmap_d;
      req_vld_q   <= req_vld_d;
      req_addr_q  <= req_addr_d;
      req_mdata_q <= req_mdata_d;
      done_q      <= done_d;
    end
  end

  // Reorder slots are cleared on reset so blk_data starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) slot_q[i] <= '0;
    end else if (rsp_wr) begin
      slot_q[rsp_tag] <= rd_rsp_data;
    end
  end

`ifdef RS_RD_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;
  logic        stall;

  // A stall is a cycle with lines left to issue but held off by almost-full or the in-flight limit.
  assign stall = (state_q == S_RD_FETCH) && !all_issued && (c0_tx_alm_full || !room);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if ((state_q == S_RD_IDLE) && start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (stall && (perf_stalls_q != '1)) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_rs_rd_fetch_engine.sv
// Bench for rs_rd_fetch_engine: table of buffer descriptors with hand-computed line counts and
// line addresses, a host-memory responder (in order, reversed, delayed, random order) and
// hand-written sequences for reset with reads in flight.
module tb_rs_rd_fetch_engine;
  localparam int ADDR_W = 42;

  logic              clk, rst_n, start;
  logic [63:0]       buf_addr;
  logic [31:0]       buf_size;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [15:0]       rd_req_mdata;
  logic              c0_tx_alm_full, rd_rsp_valid;
  logic [15:0]       rd_rsp_mdata;
  logic [511:0]      rd_rsp_data;
  logic              blk_valid, blk_last, blk_ready, busy, done;
  logic [511:0]      blk_data;
  logic [31:0]       perf_cycles, perf_stalls;

  rs_rd_fetch_engine #(.MAX_OUTSTANDING(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .buf_addr(buf_addr), .buf_size(buf_size),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .c0_tx_alm_full(c0_tx_alm_full), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data), .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last),
    .blk_ready(blk_ready), .busy(busy), .done(done), .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]       buf_addr;
    logic [31:0]       buf_size;
    int                mode;      // 0 in order, 1 reversed, 2 delayed 50, 3 random order
    bit                alm_win;   // 20-cycle almost-full window plus a start while busy
    bit                rnd_rdy;   // random blk_ready
    int                exp_lines;
    logic [ADDR_W-1:0] exp_first;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Host memory contents as a function of the cache-line address.
  function automatic logic [511:0] data_of(input logic [ADDR_W-1:0] a);
    logic [511:0] d;
    for (int i = 0; i < 16; i++)
      d[i*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * 32'(i + 1)) ^ {a[41:32], 22'h0};
    return d;
  endfunction

  task automatic run_case(input int id, input vec_t v);
    int sent_at[64];
    int due[64];
    int k, n_req, n_blk, n_done, done_k, first_k, max_out, busy_cnt, alm_left, best;
    int v_alm, v_addr, v_early, v_lat, v_stable, v_extra;
    bit alm_prev, alm_started, hold_prev, rdy, busy_k1;
    logic [511:0]      data_prev;
    logic [ADDR_W-1:0] first_addr, last_addr;
    for (int j = 0; j < 64; j++) begin
      sent_at[j] = -1;
      due[j]     = 1 << 30;
    end
    k = 0; n_req = 0; n_blk = 0; n_done = 0; done_k = 0; first_k = -1; max_out = 0;
    busy_cnt = 0; alm_left = 0; v_alm = 0; v_addr = 0; v_early = 0; v_lat = 0;
    v_stable = 0; v_extra = 0; alm_prev = 0; alm_started = 0; hold_prev = 0; busy_k1 = 0;
    data_prev = '0; first_addr = '0; last_addr = '0;
    @(negedge clk);
    buf_addr = v.buf_addr; buf_size = v.buf_size; start = 1'b1;
    rd_rsp_valid = 1'b0; c0_tx_alm_full = 1'b0; blk_ready = 1'b1;
    while (1) begin
      @(negedge clk);
      k++;
      start = 1'b0; buf_addr = v.buf_addr; buf_size = v.buf_size;
      if (k == 1) busy_k1 = busy;
      if (busy) busy_cnt++;
      // request channel
      if (rd_req_valid) begin
        if (alm_prev) v_alm++;
        if (rd_req_addr !== v.exp_first + 42'(n_req) || rd_req_mdata !== 16'(n_req % 16)) v_addr++;
        if (n_req == 0) begin
          first_k    = k;
          first_addr = rd_req_addr;
        end
        last_addr = rd_req_addr;
        if (n_req < 64) begin
          case (v.mode)
            0:       due[n_req] = k;
            2:       due[n_req] = k + 50;
            3:       due[n_req] = k + int'($urandom_range(0, 6));
            default: due[n_req] = 1 << 30;
          endcase
        end
        n_req++;
        if (v.mode == 1 && n_req == v.exp_lines)
          for (int j = 0; j < n_req; j++) due[j] = k + (n_req - 1 - j);
        if (n_req - n_blk > max_out) max_out = n_req - n_blk;
      end
      // block stream
      if (hold_prev && (!blk_valid || blk_data !== data_prev)) v_stable++;
      if (blk_valid) begin
        if (n_blk >= v.exp_lines) v_extra++;
        else if (sent_at[n_blk] < 0) v_early++;
      end else if (n_blk < v.exp_lines && sent_at[n_blk] >= 0) begin
        v_lat++;
      end
      if (done) begin
        n_done++;
        done_k = k;
      end
      rdy = v.rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      blk_ready = rdy;
      if (blk_valid && rdy && n_blk < v.exp_lines) begin
        check_wide($sformatf("v%0d_blk%0d_data", id, n_blk), blk_data,
                   data_of(v.exp_first + 42'(n_blk)));
        check_int($sformatf("v%0d_blk%0d_last", id, n_blk), int'(blk_last),
                  int'(n_blk == v.exp_lines - 1));
        n_blk++;
      end
      hold_prev = blk_valid && !rdy;
      data_prev = blk_data;
      // response channel: earliest-due pending read goes next
      best = -1;
      for (int j = 0; j < n_req && j < 64; j++)
        if (sent_at[j] < 0 && due[j] <= k && (best < 0 || due[j] < due[best])) best = j;
      if (best >= 0) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = 16'(best % 16);
        rd_rsp_data  = data_of(v.exp_first + 42'(best));
        sent_at[best] = k;
      end else begin
        rd_rsp_valid = 1'b0;
      end
      // almost-full window and an ignored start while busy
      if (v.alm_win && !alm_started && n_req >= 3) begin
        alm_started = 1;
        alm_left    = 20;
      end
      c0_tx_alm_full = (alm_left > 0);
      if (alm_left > 0) alm_left--;
      alm_prev = c0_tx_alm_full;
      if (v.alm_win && k == 10) begin
        start = 1'b1; buf_addr = 64'h0; buf_size = 32'd64;
      end
      if (n_done > 0 && k >= done_k + 3) break;
      if (k >= 4000) begin
        checks++;
        errors++;
        $display("FAIL v%0d_timeout: blocks=%0d required=%0d", id, n_blk, v.exp_lines);
        break;
      end
    end
    rd_rsp_valid = 1'b0; c0_tx_alm_full = 1'b0; blk_ready = 1'b1;
    check_int($sformatf("v%0d_req_count", id), n_req, v.exp_lines);
    check_int($sformatf("v%0d_blk_count", id), n_blk, v.exp_lines);
    check_int($sformatf("v%0d_done_count", id), n_done, 1);
    check_int($sformatf("v%0d_busy_after_start", id), int'(busy_k1), 1);
    check_int($sformatf("v%0d_busy_end", id), int'(busy), 0);
    if (v.exp_lines == 0) begin
      check_int($sformatf("v%0d_done_latency", id), done_k, 2);
    end else begin
      check_int($sformatf("v%0d_first_req_latency", id), first_k, 2);
      check_wide($sformatf("v%0d_first_addr", id), 512'(first_addr), 512'(v.exp_first));
      check_wide($sformatf("v%0d_last_addr", id), 512'(last_addr), 512'(v.exp_last));
    end
    check_int($sformatf("v%0d_req_during_alm_full", id), v_alm, 0);
    check_int($sformatf("v%0d_req_addr_tag_errs", id), v_addr, 0);
    check_int($sformatf("v%0d_blk_before_rsp", id), v_early, 0);
    check_int($sformatf("v%0d_blk_valid_late", id), v_lat, 0);
    check_int($sformatf("v%0d_blk_unstable", id), v_stable, 0);
    check_int($sformatf("v%0d_extra_blk", id), v_extra, 0);
    check_int($sformatf("v%0d_outstanding_le16", id), int'(max_out <= 16), 1);
    if (v.mode == 2) check_int($sformatf("v%0d_outstanding_max", id), max_out, 16);
`ifdef RS_RD_PERF_CNT_EN
    check_int($sformatf("v%0d_perf_cycles", id), int'(perf_cycles), busy_cnt);
    if (v.alm_win) check_int($sformatf("v%0d_perf_stalls_ge20", id), int'(perf_stalls >= 20), 1);
`else
    check_wide($sformatf("v%0d_perf_tied0", id), 512'({perf_cycles, perf_stalls}), 512'(0));
`endif
  endtask

  initial begin
    int n;
    vecs[0] = '{64'h0,                   32'd0,    0, 0, 0, 0,  42'h0,           42'h0};
    vecs[1] = '{64'h1000,                32'd200,  0, 0, 0, 4,  42'h40,          42'h43};
    vecs[2] = '{64'h2000,                32'd512,  1, 0, 0, 8,  42'h80,          42'h87};
    vecs[3] = '{64'h10000,               32'd2560, 2, 0, 0, 40, 42'h400,         42'h427};
    vecs[4] = '{64'hABCD_FFFF_FFFF_FFBF, 32'd193,  3, 0, 0, 4,  42'h3FF_FFFF_FFFE, 42'h1};
    vecs[5] = '{64'h4000,                32'd1280, 3, 1, 1, 20, 42'h100,         42'h113};
    vecs[6] = '{64'h40,                  32'd1,    0, 0, 0, 1,  42'h1,           42'h1};

    rst_n = 1'b0; start = 1'b0; buf_addr = '0; buf_size = '0; c0_tx_alm_full = 1'b0;
    rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0; blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_wide("reset_ctrl", 512'({rd_req_valid, blk_valid, blk_last, done, busy}), 512'(0));
    check_wide("reset_req", 512'({rd_req_addr, rd_req_mdata}), 512'(0));
    check_wide("reset_blk_data", blk_data, 512'(0));
    check_wide("reset_perf", 512'({perf_cycles, perf_stalls}), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

    // Reset with five reads in flight, then late responses must be ignored.
    @(negedge clk);
    buf_addr = 64'h8000; buf_size = 32'd512; start = 1'b1; blk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      @(negedge clk);
      if (rd_req_valid) n++;
    end
    check_int("rst_reads_in_flight", n, 5);
    rst_n = 1'b0;
    #1;
    check_wide("rst_mid_ctrl", 512'({rd_req_valid, blk_valid, blk_last, done, busy}), 512'(0));
    check_wide("rst_mid_req", 512'({rd_req_addr, rd_req_mdata}), 512'(0));
    check_wide("rst_mid_blk_data", blk_data, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = 16'(t);
      rd_rsp_data  = data_of(42'h200 + 42'(t));
      @(negedge clk);
      check_int($sformatf("rst_late_rsp%0d", t), int'({blk_valid, busy, rd_req_valid, done}), 0);
    end
    rd_rsp_valid = 1'b0;
    @(negedge clk);
    check_int("rst_late_rsp_final", int'({blk_valid, busy}), 0);
    run_case(7, vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
